fp_mul_norm_round: RTL and testbench

FP_MUL_NORM_ROUND -- requirements
Module: fp_mul_norm_round

---
 rtl/fp_mul_norm_round.sv | 141 ++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
// Normalize-and-round back end of a binary32 multiplier: takes the raw significand
// product and exponent sum, produces the RNE-rounded result with flags in two stages.
module fp_mul_norm_round (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp_sum,
  input  logic [47:0] in_prod,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  // Stage 1 state: normalized significand plus rounding bits.
  logic               s1_valid;
  logic               s1_sign;
  logic signed [10:0] s1_e;
  logic [22:0]        s1_mant;
  logic               s1_guard;
  logic               s1_sticky;
  special_t           s1_special;

  logic               s2_can_load;
  logic signed [10:0] n_e;
  logic [22:0]        n_mant;
  logic               n_guard;
  logic               n_sticky;
  special_t           n_special;

  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;

  // A leading one at bit 47 means the product is in [2,4): shift one further and bump e.
  assign n_e = $signed({2'b00, in_exp_sum}) - 11'sd127 + $signed({10'd0, in_prod[47]});

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    n_mant    = in_prod[45:23];
    n_guard   = in_prod[22];
    n_sticky  = |in_prod[21:0];
    n_special = SP_NONE;
    if (in_prod[47]) begin
      n_mant   = in_prod[46:24];
      n_guard  = in_prod[23];
      n_sticky = |in_prod[22:0];
    end
    if (in_nan || (in_inf && in_zero)) n_special = SP_NAN;
    else if (in_inf)                   n_special = SP_INF;
    else if (in_zero)                  n_special = SP_ZERO;
  end

  // NOTE: datapath registers are reset too, so the reset-state outputs are fully defined.
  // NOTE: sequential state uses non-blocking assignments only, to avoid update-order races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_e       <= '0;
      s1_mant    <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
      s1_special <= SP_NONE;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_e       <= n_e;
        s1_mant    <= n_mant;
        s1_guard   <= n_guard;
        s1_sticky  <= n_sticky;
        s1_special <= n_special;
      end
    end
  end

  logic               r_inc;
  logic               r_carry;
  logic [22:0]        r_mant;
  logic signed [10:0] r_e;
  logic [31:0]        r_result;
  logic               r_ov;
  logic               r_un;
  logic               r_ix;

  assign r_inc              = s1_guard && (s1_sticky || s1_mant[0]);
  assign {r_carry, r_mant}  = {1'b0, s1_mant} + {23'd0, r_inc};
  assign r_e                = s1_e + $signed({10'd0, r_carry});

  always_comb begin
    r_result = {s1_sign, r_e[7:0], r_mant};
    r_ov     = 1'b0;
    r_un     = 1'b0;
    r_ix     = s1_guard || s1_sticky;
    unique case (s1_special)
      SP_NAN:  begin r_result = 32'h7FC0_0000;           r_ix = 1'b0; end
      SP_INF:  begin r_result = {s1_sign, 8'hFF, 23'h0}; r_ix = 1'b0; end
      SP_ZERO: begin r_result = {s1_sign, 31'h0};        r_ix = 1'b0; end
      default: begin
        if (r_e >= 11'sd255) begin
          r_result = {s1_sign, 8'hFF, 23'h0};
          r_ov     = 1'b1;
          r_ix     = 1'b1;
        end else if (r_e <= 11'sd0) begin
          r_result = {s1_sign, 31'h0};
          r_un     = 1'b1;
          r_ix     = 1'b1;
        end
      end
    endcase
  end

  // Stage 2 only updates when it can load, which keeps the output frozen under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid     <= 1'b0;
      out_result    <= 32'h0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= r_result;
        out_overflow  <= r_ov;
        out_underflow <= r_un;
        out_inexact   <= r_ix;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed vectors, an arithmetic
// reference model with scoreboard, hold-stability, backpressure and reset checks.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp_sum;
  logic [47:0] in_prod;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  always #5 clk = ~clk;

  fp_mul_norm_round dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp_sum(in_exp_sum), .in_prod(in_prod),
    .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        ix;
  } exp_t;

  typedef struct packed {
    logic        s;
    logic [8:0]  es;
    logic [47:0] p;
    logic        z;
    logic        inf;
    logic        nan;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic held_v = 1'b0;
  exp_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: treat the product as an integer, split off the discarded tail and
  // round by comparing it against one half ulp.
  function automatic exp_t model(input vec_t v);
    exp_t        r;
    int          e;
    int          sh;
    logic [63:0] pp, kept, rem, half, mant;
    r = '0;
    if (v.nan || (v.inf && v.z)) begin r.res = 32'h7FC0_0000; return r; end
    if (v.inf) begin r.res = {v.s, 8'hFF, 23'h0}; return r; end
    if (v.z)   begin r.res = {v.s, 31'h0};        return r; end
    e  = int'(v.es) - 127;
    sh = v.p[47] ? 24 : 23;
    if (v.p[47]) e++;
    pp   = {16'd0, v.p};
    kept = pp >> sh;
    rem  = pp & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    mant = kept % (64'd1 << 23);
    if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
    if (mant == (64'd1 << 23)) begin mant = 64'd0; e++; end
    if (e >= 255) begin
      r.res = {v.s, 8'hFF, 23'h0}; r.ov = 1'b1; r.ix = 1'b1;
    end else if (e <= 0) begin
      r.res = {v.s, 31'h0}; r.un = 1'b1; r.ix = 1'b1;
    end else begin
      r.res = {v.s, e[7:0], mant[22:0]};
      r.ix  = (rem != 64'd0);
    end
    return r;
  endfunction

  // Compare process: inputs only change just after a rising edge, so at the falling
  // edge the handshake signals show exactly what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("hold_stable", {out_result, out_overflow, out_underflow, out_inexact}, held);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_output", {out_result, out_overflow, out_underflow, out_inexact}, 64'hX);
        end else begin
          check("result", {out_result, out_overflow, out_underflow, out_inexact}, sbq.pop_front());
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_result, out_overflow, out_underflow, out_inexact};
      if (in_valid && in_ready)
        sbq.push_back(model({in_sign, in_exp_sum, in_prod, in_zero, in_inf, in_nan}));
    end
  end

  task automatic drive(input vec_t v);
    in_sign    = v.s;
    in_exp_sum = v.es;
    in_prod    = v.p;
    in_zero    = v.z;
    in_inf     = v.inf;
    in_nan     = v.nan;
    in_valid   = 1'b1;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  vec_t vecs[12];
  int   acc;

  initial begin
    vecs[0]  = {1'b0, 9'd254, 48'h4000_0000_0000, 3'b000}; // 1.0 x 1.0
    vecs[1]  = {1'b0, 9'd254, 48'h9000_0000_0000, 3'b000}; // 1.5 x 1.5
    vecs[2]  = {1'b0, 9'd254, 48'h4000_0040_0000, 3'b000}; // tie, stays even
    vecs[3]  = {1'b0, 9'd254, 48'h4000_00C0_0000, 3'b000}; // tie, rounds up
    vecs[4]  = {1'b1, 9'd510, 48'h8000_0000_0000, 3'b000}; // overflow
    vecs[5]  = {1'b0, 9'd100, 48'h4000_0000_0000, 3'b000}; // underflow
    vecs[6]  = {1'b0, 9'd254, 48'h4000_0000_0000, 3'b110}; // inf x zero
    vecs[7]  = {1'b0, 9'd254, 48'h7FFF_FFC0_0000, 3'b000}; // mantissa carry
    vecs[8]  = {1'b0, 9'd381, 48'h7FFF_FFC0_0000, 3'b000}; // overflow by rounding
    vecs[9]  = {1'b1, 9'd128, 48'h4000_0000_0001, 3'b100}; // signed zero special
    vecs[10] = {1'b0, 9'd127, 48'h4000_0000_0000, 3'b000}; // e == 0 boundary
    vecs[11] = {1'b0, 9'd128, 48'h4000_0000_0001, 3'b000}; // smallest normal, sticky only

    check("pin_1x1",    model(vecs[0]),  {32'h3F80_0000, 3'b000});
    check("pin_15x15",  model(vecs[1]),  {32'h4010_0000, 3'b000});
    check("pin_tie_ev", model(vecs[2]),  {32'h3F80_0000, 3'b001});
    check("pin_tie_up", model(vecs[3]),  {32'h3F80_0002, 3'b001});
    check("pin_ovf",    model(vecs[4]),  {32'hFF80_0000, 3'b101});
    check("pin_unf",    model(vecs[5]),  {32'h0000_0000, 3'b011});
    check("pin_infz",   model(vecs[6]),  {32'h7FC0_0000, 3'b000});
    check("pin_carry",  model(vecs[7]),  {32'h4000_0000, 3'b001});
    check("pin_rnd_ov", model(vecs[8]),  {32'h7F80_0000, 3'b101});
    check("pin_e0",     model(vecs[10]), {32'h0000_0000, 3'b011});
    check("pin_minnrm", model(vecs[11]), {32'h0080_0000, 3'b001});

    rstn = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_outputs", {out_result, out_overflow, out_underflow, out_inexact}, 64'd0);

    // Input held valid across reset release: first rising edge after release accepts it.
    rstn = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_cycle1", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2", {63'd0, out_valid}, 64'd1);
    check("lat_value", {out_result, out_overflow, out_underflow, out_inexact}, {32'h3F80_0000, 3'b000});
    @(posedge clk); #1;

    foreach (vecs[k]) send(vecs[k]);
    repeat (4) @(posedge clk);
    #1;
    check("drain_1", sbq.size(), 64'd0);

    // Backpressure: offer back-to-back inputs while downstream is stalled for 4 cycles.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(vecs[acc + 1]);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts",  acc, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_2", sbq.size(), 64'd0);

    // Asynchronous reset while a result is waiting at the output.
    out_ready = 1'b0;
    send(vecs[4]);
    @(posedge clk); #1;
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_result", {32'd0, out_result}, 64'd0);
    check("async_rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    send(vecs[1]);
    send(vecs[3]);
    repeat (4) @(posedge clk);
    #1;
    check("drain_3", sbq.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
